// File: rtl/pipeline_processor.sv
`timescale 1ns/1ps
// Five-stage in-order MIPS subset core (IF/ID/EX/MEM/WB) with internal instruction ROM and data RAM.
// Optional macro FORWARDING_EN adds EX operand forwarding and a one-cycle load-use stall.
module pipeline_processor #(
  parameter int    IMEM_DEPTH = 64,
  parameter int    DMEM_DEPTH = 64,
  parameter string IMEM_FILE  = "program.hex"
) (
  input  logic clk,
  input  logic reset
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    reg_dst;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc4;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } id_ex_t;

  // Unsupported encodings (including all-zero) decode to an all-zero control word.
  function automatic ctrl_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c = '0;
        endcase
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_SUB;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  logic [31:0] imem    [IMEM_DEPTH];
  logic [31:0] dmem    [DMEM_DEPTH];
  logic [31:0] regfile [32];

  initial begin
    for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] = '0;
  end

  // Pipeline state
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic [31:0] if_id_pc4;
  id_ex_t      id_ex;
  logic        ex_mem_reg_write;
  logic        ex_mem_mem_to_reg;
  logic        ex_mem_mem_write;
  logic [31:0] alu_out;
  logic [31:0] ex_mem_store;
  logic [4:0]  ex_mem_dest;
  logic        RegWrite_mem_wb;
  logic        mem_to_reg_mem_wb;
  logic [31:0] alu_mem_wb;
  logic [31:0] mem_data_out;
  logic [4:0]  rd_mem_wb;

  // Combinational stage logic
  logic [31:0] fetch_instr;
  logic [31:0] pc_plus4;
  id_ex_t      id_next;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [4:0]  ex_dest;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic        load_use;
  logic        unused_bits;

  assign unused_bits = ^instruction_out[10:6];

  // IF: ROM words past the end of the image read as NOP.
  assign pc_plus4    = pc_out + 32'd4;
  assign fetch_instr = (pc_out[31:2] < 30'(IMEM_DEPTH)) ? imem[pc_out[IAW+1:2]] : '0;

  // ID: register reads see the value WB is writing this same cycle.
  assign id_rs = instruction_out[25:21];
  assign id_rt = instruction_out[20:16];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    id_next      = '0;
    id_next.ctrl = decode(instruction_out[31:26], instruction_out[5:0]);
    id_next.pc4  = if_id_pc4;
    id_next.imm  = {{16{instruction_out[15]}}, instruction_out[15:0]};
    id_next.rs   = id_rs;
    id_next.rt   = id_rt;
    id_next.rd   = instruction_out[15:11];
    if (id_rs == '0)                                 id_next.a = '0;
    else if (RegWrite_mem_wb && rd_mem_wb == id_rs)  id_next.a = wb_data;
    else                                             id_next.a = regfile[id_rs];
    if (id_rt == '0)                                 id_next.b = '0;
    else if (RegWrite_mem_wb && rd_mem_wb == id_rt)  id_next.b = wb_data;
    else                                             id_next.b = regfile[id_rt];
  end

  // EX operand selection
  always_comb begin
    ex_a = id_ex.a;
    ex_b = id_ex.b;
`ifdef FORWARDING_EN
    if (ex_mem_reg_write && ex_mem_dest != '0 && ex_mem_dest == id_ex.rs)
      ex_a = alu_out;
    else if (RegWrite_mem_wb && rd_mem_wb != '0 && rd_mem_wb == id_ex.rs)
      ex_a = wb_data;
    if (ex_mem_reg_write && ex_mem_dest != '0 && ex_mem_dest == id_ex.rt)
      ex_b = alu_out;
    else if (RegWrite_mem_wb && rd_mem_wb != '0 && rd_mem_wb == id_ex.rt)
      ex_b = wb_data;
`endif
  end

`ifdef FORWARDING_EN
  // A load still in EX cannot forward yet, so hold its consumer in ID for one cycle.
  assign load_use = id_ex.ctrl.mem_read && (id_ex.rt == id_rs || id_ex.rt == id_rt);
`else
  assign load_use = 1'b0;
`endif

  assign alu_b = id_ex.ctrl.alu_src ? id_ex.imm : ex_b;

  always_comb begin
    alu_result = '0;
    case (id_ex.ctrl.alu_op)
      ALU_ADD: alu_result = ex_a + alu_b;
      ALU_SUB: alu_result = ex_a - alu_b;
      ALU_AND: alu_result = ex_a & alu_b;
      ALU_OR:  alu_result = ex_a | alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(ex_a) < $signed(alu_b)};
      default: alu_result = '0;
    endcase
  end

  assign ex_dest       = id_ex.ctrl.reg_dst ? id_ex.rd : id_ex.rt;
  assign branch_taken  = id_ex.ctrl.branch && (ex_a == ex_b);
  assign branch_target = id_ex.pc4 + {id_ex.imm[29:0], 2'b00};

  // MEM / WB
  assign mem_rdata = dmem[alu_out[DAW+1:2]];
  assign wb_data   = mem_to_reg_mem_wb ? mem_data_out : alu_mem_wb;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out            <= '0;
      instruction_out   <= '0;
      if_id_pc4         <= '0;
      id_ex             <= '0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_to_reg <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
      alu_out           <= '0;
      ex_mem_store      <= '0;
      ex_mem_dest       <= '0;
      RegWrite_mem_wb   <= 1'b0;
      mem_to_reg_mem_wb <= 1'b0;
      alu_mem_wb        <= '0;
      mem_data_out      <= '0;
      rd_mem_wb         <= '0;
    end else begin
      ex_mem_reg_write  <= id_ex.ctrl.reg_write;
      ex_mem_mem_to_reg <= id_ex.ctrl.mem_to_reg;
      ex_mem_mem_write  <= id_ex.ctrl.mem_write;
      alu_out           <= alu_result;
      ex_mem_store      <= ex_b;
      ex_mem_dest       <= ex_dest;

      RegWrite_mem_wb   <= ex_mem_reg_write;
      mem_to_reg_mem_wb <= ex_mem_mem_to_reg;
      alu_mem_wb        <= alu_out;
      mem_data_out      <= mem_rdata;
      rd_mem_wb         <= ex_mem_dest;

      // A taken branch squashes the two younger instructions and overrides any stall.
      if (branch_taken) begin
        pc_out          <= branch_target;
        instruction_out <= '0;
        if_id_pc4       <= '0;
        id_ex           <= '0;
      end else if (load_use) begin
        id_ex <= '0;
      end else begin
        pc_out          <= pc_plus4;
        instruction_out <= fetch_instr;
        if_id_pc4       <= pc_plus4;
        id_ex           <= id_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (RegWrite_mem_wb && rd_mem_wb != '0) begin
      regfile[rd_mem_wb] <= wb_data;
    end
  end

  // NOTE: the data RAM has no reset so it maps onto plain RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && ex_mem_mem_write) dmem[alu_out[DAW+1:2]] <= ex_mem_store;
  end

endmodule

// File: tb/tb_pipeline_processor.sv
`timescale 1ns/1ps
// Directed bench for pipeline_processor: preloads a program, scoreboards every register
// write-back in order, and probes pipeline state at fixed edges after reset.
module tb_pipeline_processor;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pipeline_processor #(.IMEM_FILE("")) dut (
    .clk   (clk),
    .reset (reset)
  );

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    bit          is_load;
  } wb_t;

  wb_t         sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cur    = 0;
  logic [31:0] prog [26];
  logic [31:0] exp_regs [32];

  function automatic logic [31:0] r_op(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt,
                                       logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_op(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                       logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] val, input bit is_load);
    wb_t e;
    e.rd = rd;
    e.val = val;
    e.is_load = is_load;
    sb.push_back(e);
  endtask

  // Expected write-back order for one pass of the program from PC 0.
  task automatic push_program();
    push(5'd1,  32'd5,        1'b0);
    push(5'd2,  32'd7,        1'b0);
    push(5'd3,  32'd12,       1'b0);
    push(5'd5,  32'hFFFFFFFE, 1'b0);
    push(5'd6,  32'd1,        1'b0);
    push(5'd4,  32'd12,       1'b1);
    push(5'd11, 32'd1,        1'b0);
    push(5'd12, 32'd2,        1'b0);
    push(5'd7,  32'd12,       1'b0);
    push(5'd8,  FWD ? 32'd17 : 32'd5, 1'b0);
    push(5'd13, 32'd12,       1'b1);
    push(5'd14, FWD ? 32'd17 : 32'd5, 1'b0);
  endtask

  task automatic to_edge(input int k);
    while (cur < k) begin
      @(posedge clk);
      cur++;
    end
    @(negedge clk);
  endtask

  // Write-back monitor: every register write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (dut.RegWrite_mem_wb === 1'b1) begin
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL wb_unexpected: observed rd=%0d data=%h expected no write-back",
               dut.rd_mem_wb, dut.wb_data);
      end
      if (sb.size() != 0) begin
        wb_t e;
        e = sb.pop_front();
        check("wb_rd", 32'(dut.rd_mem_wb), 32'(e.rd));
        check("wb_data", dut.wb_data, e.val);
        if (e.is_load) check("load_data", dut.mem_data_out, e.val);
      end
    end
  end

  initial begin
    reset = 1'b1;

    prog[0]  = i_op(6'h08, 5'd0, 5'd1, 16'd5);     // addi $1,$0,5
    prog[1]  = i_op(6'h08, 5'd0, 5'd2, 16'd7);     // addi $2,$0,7
    prog[2]  = 32'h0;
    prog[3]  = 32'h0;
    prog[4]  = 32'h0;
    prog[5]  = r_op(5'd3, 5'd1, 5'd2, 6'h20);      // add $3,$1,$2
    prog[6]  = r_op(5'd5, 5'd1, 5'd2, 6'h22);      // sub $5,$1,$2
    prog[7]  = r_op(5'd6, 5'd1, 5'd2, 6'h2A);      // slt $6,$1,$2
    prog[8]  = i_op(6'h2B, 5'd0, 5'd3, 16'd4);     // sw  $3,4($0)
    prog[9]  = 32'h0;
    prog[10] = 32'h0;
    prog[11] = i_op(6'h23, 5'd0, 5'd4, 16'd4);     // lw  $4,4($0)
    prog[12] = i_op(6'h04, 5'd1, 5'd1, 16'd2);     // beq $1,$1,+2 (taken)
    prog[13] = i_op(6'h08, 5'd0, 5'd9, 16'd99);    // squashed
    prog[14] = i_op(6'h08, 5'd0, 5'd10, 16'd99);   // squashed
    prog[15] = i_op(6'h04, 5'd1, 5'd2, 16'd2);     // beq $1,$2,+2 (not taken)
    prog[16] = i_op(6'h08, 5'd0, 5'd11, 16'd1);    // addi $11,$0,1
    prog[17] = i_op(6'h08, 5'd0, 5'd12, 16'd2);    // addi $12,$0,2
    prog[18] = r_op(5'd7, 5'd1, 5'd2, 6'h20);      // add $7,$1,$2
    prog[19] = r_op(5'd8, 5'd7, 5'd1, 6'h20);      // add $8,$7,$1
    prog[20] = i_op(6'h23, 5'd0, 5'd13, 16'd4);    // lw  $13,4($0)
    prog[21] = r_op(5'd14, 5'd13, 5'd1, 6'h20);    // add $14,$13,$1
    prog[22] = 32'h0;
    prog[23] = 32'h0;
    prog[24] = 32'h0;
    prog[25] = i_op(6'h04, 5'd0, 5'd0, 16'hFFFF);  // beq $0,$0,-1 (spin)

    for (int i = 0; i < 64; i++) dut.imem[i] = (i < 26) ? prog[i] : 32'h0;
    push_program();

    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pc", dut.pc_out, 32'd0);
    check("rst_regwrite", 32'(dut.RegWrite_mem_wb), 32'd0);
    reset = 1'b0;
    cur   = 0;

    to_edge(1);
    check("pc_e1", dut.pc_out, 32'd4);
    check("ifid_e1", dut.instruction_out, prog[0]);
    to_edge(2);
    check("pc_e2", dut.pc_out, 32'd8);
    to_edge(3);
    check("pc_e3", dut.pc_out, 32'd12);
    to_edge(5);
    check("r1_e5", dut.regfile[1], 32'd5);

    // One-cycle reset while add $3 is heading into EX/MEM
    to_edge(7);
    check("sb_pending", 32'(sb.size()), 32'd10);
    reset = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    push_program();
    @(negedge clk);
    check("mid_rst_pc", dut.pc_out, 32'd0);
    check("mid_rst_ifid", dut.instruction_out, 32'd0);
    check("mid_rst_alu", dut.alu_out, 32'd0);
    check("mid_rst_memdata", dut.mem_data_out, 32'd0);
    check("mid_rst_regwrite", 32'(dut.RegWrite_mem_wb), 32'd0);
    check("mid_rst_r1", dut.regfile[1], 32'd0);
    check("mid_rst_r2", dut.regfile[2], 32'd0);
    reset = 1'b0;
    cur   = 0;

    // Full pass from PC 0
    to_edge(8);
    check("alu_add", dut.alu_out, 32'h0000000C);
    to_edge(9);
    check("alu_sub", dut.alu_out, 32'hFFFFFFFE);
    to_edge(10);
    check("alu_slt", dut.alu_out, 32'h00000001);
    check("r3_wb", dut.regfile[3], 32'd12);
    to_edge(15);
    check("lw_memdata", dut.mem_data_out, 32'h0000000C);
    check("lw_regwrite", 32'(dut.RegWrite_mem_wb), 32'd1);
    check("beq_target_pc", dut.pc_out, 32'd60);
    to_edge(16);
    check("r4_wb", dut.regfile[4], 32'd12);
    to_edge(24);
    check("r8_dep", dut.regfile[8], FWD ? 32'd17 : 32'd5);
    to_edge(26);
    check("r14_e26", dut.regfile[14], FWD ? 32'd0 : 32'd5);
    to_edge(27);
    check("r14_e27", dut.regfile[14], FWD ? 32'd17 : 32'd5);

    to_edge(40);
    check("sb_drained", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 32; i++) exp_regs[i] = 32'd0;
    exp_regs[1]  = 32'd5;
    exp_regs[2]  = 32'd7;
    exp_regs[3]  = 32'd12;
    exp_regs[4]  = 32'd12;
    exp_regs[5]  = 32'hFFFFFFFE;
    exp_regs[6]  = 32'd1;
    exp_regs[7]  = 32'd12;
    exp_regs[8]  = FWD ? 32'd17 : 32'd5;
    exp_regs[11] = 32'd1;
    exp_regs[12] = 32'd2;
    exp_regs[13] = 32'd12;
    exp_regs[14] = FWD ? 32'd17 : 32'd5;
    for (int i = 0; i < 32; i++) check($sformatf("final_r%0d", i), dut.regfile[i], exp_regs[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
